// File: rtl/pipe_ctrl_if.sv
// Bundle between the hazard unit / fetch side and the pipeline sequencing block.
// master drives fetch data and stall; slave (pipe_ctrl) returns stage state.
interface pipe_ctrl_if;
  logic [31:0] Instr_F;
  logic [31:0] PC_F;
  logic        Stall;

  logic        En_PC;
  logic        En_D;
  logic [31:0] Instr_D;
  logic [31:0] Instr_E;
  logic [31:0] Instr_M;
  logic [31:0] Instr_W;
  logic [31:0] PC_D;
  logic [31:0] PC_E;
  logic [31:0] PC_M;
  logic [31:0] PC_W;
  logic        Valid_E;
  logic        Valid_M;
  logic        Valid_W;
  logic        Retire_W;
  logic        Stall_err;
  logic [31:0] Cyc_cnt;
  logic [31:0] Ret_cnt;
  logic [31:0] Stl_cnt;

  modport master (
    output Instr_F, PC_F, Stall,
    input  En_PC, En_D,
    input  Instr_D, Instr_E, Instr_M, Instr_W,
    input  PC_D, PC_E, PC_M, PC_W,
    input  Valid_E, Valid_M, Valid_W, Retire_W, Stall_err,
    input  Cyc_cnt, Ret_cnt, Stl_cnt
  );

  modport slave (
    input  Instr_F, PC_F, Stall,
    output En_PC, En_D,
    output Instr_D, Instr_E, Instr_M, Instr_W,
    output PC_D, PC_E, PC_M, PC_W,
    output Valid_E, Valid_M, Valid_W, Retire_W, Stall_err,
    output Cyc_cnt, Ret_cnt, Stl_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing: carries instruction/PC through D/E/M/W, freezes F/D and bubbles E on Stall.
// Optional performance counters built only when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int unsigned MAX_STALL = 2
) (
  input  logic          clk,
  input  logic          reset,
  pipe_ctrl_if.slave    bus
);

  localparam int unsigned      RunW    = $clog2(MAX_STALL + 2);
  localparam logic [RunW-1:0] RunTrip = RunW'(MAX_STALL);
  localparam logic [RunW-1:0] RunSat  = RunW'(MAX_STALL + 1);

  logic            w_stall;
  logic            w_retire;
  logic [RunW-1:0] w_run_d;

  logic [31:0]     r_instr_d, r_instr_e, r_instr_m, r_instr_w;
  logic [31:0]     r_pc_d, r_pc_e, r_pc_m, r_pc_w;
  logic            r_valid_e, r_valid_m, r_valid_w;
  logic            r_stall_err;
  logic [RunW-1:0] r_run;

  assign w_stall  = bus.Stall;
  assign w_retire = r_valid_w & (r_instr_w != 32'h0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr_d <= 32'h0;
      r_instr_e <= 32'h0;
      r_instr_m <= 32'h0;
      r_instr_w <= 32'h0;
      r_pc_d    <= RESET_PC;
      r_pc_e    <= RESET_PC;
      r_pc_m    <= RESET_PC;
      r_pc_w    <= RESET_PC;
      r_valid_e <= 1'b0;
      r_valid_m <= 1'b0;
      r_valid_w <= 1'b0;
    end else begin
      r_instr_m <= r_instr_e;
      r_instr_w <= r_instr_m;
      r_pc_m    <= r_pc_e;
      r_pc_w    <= r_pc_m;
      r_valid_m <= r_valid_e;
      r_valid_w <= r_valid_m;
      if (!w_stall) begin
        r_instr_d <= bus.Instr_F;
        r_pc_d    <= bus.PC_F;
        r_instr_e <= r_instr_d;
        r_pc_e    <= r_pc_d;
        r_valid_e <= 1'b1;
      end else begin
        // Bubble keeps the PC of the instruction it is waiting on.
        r_instr_e <= 32'h0;
        r_pc_e    <= r_pc_d;
        r_valid_e <= 1'b0;
      end
    end
  end

  always_comb begin
    w_run_d = '0;
    if (w_stall) begin
      w_run_d = (r_run == RunSat) ? RunSat : r_run + RunW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run       <= '0;
      r_stall_err <= 1'b0;
    end else begin
      r_run <= w_run_d;
      // Flag only; the pipeline keeps obeying Stall.
      if (w_stall && (r_run == RunTrip)) begin
        r_stall_err <= 1'b1;
      end
    end
  end

  assign bus.En_PC     = ~w_stall;
  assign bus.En_D      = ~w_stall;
  assign bus.Instr_D   = r_instr_d;
  assign bus.Instr_E   = r_instr_e;
  assign bus.Instr_M   = r_instr_m;
  assign bus.Instr_W   = r_instr_w;
  assign bus.PC_D      = r_pc_d;
  assign bus.PC_E      = r_pc_e;
  assign bus.PC_M      = r_pc_m;
  assign bus.PC_W      = r_pc_w;
  assign bus.Valid_E   = r_valid_e;
  assign bus.Valid_M   = r_valid_m;
  assign bus.Valid_W   = r_valid_w;
  assign bus.Retire_W  = w_retire;
  assign bus.Stall_err = r_stall_err;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_cyc_cnt, r_ret_cnt, r_stl_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cyc_cnt <= 32'h0;
      r_ret_cnt <= 32'h0;
      r_stl_cnt <= 32'h0;
    end else begin
      r_cyc_cnt <= r_cyc_cnt + 32'd1;
      if (w_retire) r_ret_cnt <= r_ret_cnt + 32'd1;
      if (w_stall)  r_stl_cnt <= r_stl_cnt + 32'd1;
    end
  end

  assign bus.Cyc_cnt = r_cyc_cnt;
  assign bus.Ret_cnt = r_ret_cnt;
  assign bus.Stl_cnt = r_stl_cnt;
`else
  assign bus.Cyc_cnt = 32'h0;
  assign bus.Ret_cnt = 32'h0;
  assign bus.Stl_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboarded bench for pipe_ctrl: driver queues each instruction entering D,
// monitor checks it when it appears valid in W; directed checks cover stall/reset cases.
module tb_pipe_ctrl;
  localparam logic [31:0] RstPc = 32'h0000_3000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  pipe_ctrl_if bus ();

  pipe_ctrl #(
    .RESET_PC  (RstPc),
    .MAX_STALL (2)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid W instruction must match the oldest queued entry.
  always @(negedge clk) begin
    if (!reset && bus.Valid_W) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_empty: Valid_W with Instr_W=%h, expected no entry", bus.Instr_W);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_instr_w", bus.Instr_W, mon_e.instr);
        chk("sb_pc_w", bus.PC_W, mon_e.pc);
        chk("sb_retire_w", {31'b0, bus.Retire_W}, {31'b0, mon_e.instr != 32'h0});
      end
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_instr_d"}, bus.Instr_D, 32'h0);
    chk({tag, "_instr_e"}, bus.Instr_E, 32'h0);
    chk({tag, "_instr_m"}, bus.Instr_M, 32'h0);
    chk({tag, "_instr_w"}, bus.Instr_W, 32'h0);
    chk({tag, "_pc_d"}, bus.PC_D, RstPc);
    chk({tag, "_pc_e"}, bus.PC_E, RstPc);
    chk({tag, "_pc_m"}, bus.PC_M, RstPc);
    chk({tag, "_pc_w"}, bus.PC_W, RstPc);
    chk({tag, "_valid"}, {29'b0, bus.Valid_E, bus.Valid_M, bus.Valid_W}, 32'h0);
    chk({tag, "_err"}, {31'b0, bus.Stall_err}, 32'h0);
    chk({tag, "_cyc"}, bus.Cyc_cnt, 32'h0);
    chk({tag, "_ret"}, bus.Ret_cnt, 32'h0);
    chk({tag, "_stl"}, bus.Stl_cnt, 32'h0);
  endtask

  // Reset spans one rising edge; D's reset nop is the first entry headed for W.
  task automatic do_reset();
    bus.Instr_F = 32'h0;
    bus.PC_F    = 32'h0;
    bus.Stall   = 1'b0;
    reset       = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb_q.delete();
    sb_q.push_back({32'h0, RstPc});
  endtask

  task automatic step(input logic [31:0] instr, input logic [31:0] pc, input logic stall);
    bus.Instr_F = instr;
    bus.PC_F    = pc;
    bus.Stall   = stall;
    @(posedge clk);
    if (!stall) sb_q.push_back({instr, pc});
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, checked before any clock edge.
    bus.Instr_F = 32'h0;
    bus.PC_F    = 32'h0;
    bus.Stall   = 1'b0;
    reset       = 1'b1;
    #1;
    chk_reset_state("rst");
    do_reset();

    // 1: I1..I4 -> I1 in W after 4th edge.
    step(32'hA000_0001, 32'h100, 1'b0);
    step(32'hA000_0002, 32'h104, 1'b0);
    step(32'hA000_0003, 32'h108, 1'b0);
    step(32'hA000_0004, 32'h10C, 1'b0);
    chk("t1_instr_w", bus.Instr_W, 32'hA000_0001);
    chk("t1_pc_w", bus.PC_W, 32'h100);
    chk("t1_valid_w", {31'b0, bus.Valid_W}, 32'h1);
    chk("t1_retire_w", {31'b0, bus.Retire_W}, 32'h1);

    // 2: one-cycle stall with I2 in D.
    do_reset();
    step(32'hB000_0001, 32'h200, 1'b0);
    step(32'hB000_0002, 32'h204, 1'b0);
    bus.Instr_F = 32'hB000_0003;
    bus.PC_F    = 32'h208;
    bus.Stall   = 1'b1;
    #1;
    chk("t2_en_pc", {31'b0, bus.En_PC}, 32'h0);
    chk("t2_en_d", {31'b0, bus.En_D}, 32'h0);
    @(posedge clk);
    #1;
    chk("t2_instr_d_hold", bus.Instr_D, 32'hB000_0002);
    chk("t2_instr_e_bubble", bus.Instr_E, 32'h0);
    chk("t2_valid_e", {31'b0, bus.Valid_E}, 32'h0);
    chk("t2_pc_e", bus.PC_E, 32'h204);
    step(32'hB000_0003, 32'h208, 1'b0);
    chk("t2_en_pc_run", {31'b0, bus.En_PC}, 32'h1);
    chk("t2_instr_e_next", bus.Instr_E, 32'hB000_0002);
    chk("t2_instr_d_next", bus.Instr_D, 32'hB000_0003);

    // 3: stall-length policing.
    do_reset();
    step(32'hC000_0001, 32'h300, 1'b0);
    step(32'hC000_0002, 32'h304, 1'b1);
    step(32'hC000_0002, 32'h304, 1'b1);
    chk("t3_err_after2", {31'b0, bus.Stall_err}, 32'h0);
    step(32'hC000_0002, 32'h304, 1'b0);
    step(32'hC000_0003, 32'h308, 1'b1);
    step(32'hC000_0003, 32'h308, 1'b1);
    chk("t3_err_before3", {31'b0, bus.Stall_err}, 32'h0);
    step(32'hC000_0003, 32'h308, 1'b1);
    chk("t3_err_after3", {31'b0, bus.Stall_err}, 32'h1);
    step(32'hC000_0003, 32'h308, 1'b0);
    step(32'hC000_0004, 32'h30C, 1'b0);
    chk("t3_err_sticky", {31'b0, bus.Stall_err}, 32'h1);
    do_reset();
    chk("t3_err_cleared", {31'b0, bus.Stall_err}, 32'h0);

    // Stall on the first cycle after reset.
    step(32'hC100_0001, 32'h380, 1'b1);
    chk("t3b_instr_d", bus.Instr_D, 32'h0);
    chk("t3b_instr_e", bus.Instr_E, 32'h0);
    chk("t3b_valid_e", {31'b0, bus.Valid_E}, 32'h0);
    step(32'hC100_0001, 32'h380, 1'b0);
    chk("t3b_instr_d_load", bus.Instr_D, 32'hC100_0001);

    // 4: asynchronous reset mid-stall with a full pipe.
    do_reset();
    for (int i = 0; i < 5; i++) step(32'hD000_0000 + 32'(i + 1), 32'h400 + 32'(4 * i), 1'b0);
    bus.Stall = 1'b1;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk_reset_state("t4");
    bus.Stall   = 1'b0;
    bus.Instr_F = 32'hD100_0001;
    bus.PC_F    = 32'h480;
    @(posedge clk);
    #1;
    chk("t4_hold_in_reset", bus.Instr_D, 32'h0);
    reset = 1'b0;
    sb_q.delete();
    sb_q.push_back({32'h0, RstPc});
    step(32'hD100_0001, 32'h480, 1'b0);
    chk("t4_instr_d_after", bus.Instr_D, 32'hD100_0001);
    chk("t4_pc_d_after", bus.PC_D, 32'h480);

    // 5: performance counters over 10 cycles, 2 stalls, 6 retirements.
    do_reset();
    for (int i = 0; i < 8; i++) step(32'hE000_0000 + 32'(i + 1), 32'h500 + 32'(4 * i), 1'b0);
    step(32'hE000_0009, 32'h520, 1'b1);
    step(32'hE000_0009, 32'h520, 1'b1);
`ifdef PIPE_PERF_CNT_EN
    chk("t5_cyc_cnt", bus.Cyc_cnt, 32'd10);
    chk("t5_stl_cnt", bus.Stl_cnt, 32'd2);
    chk("t5_ret_cnt", bus.Ret_cnt, 32'd6);
`else
    chk("t5_cyc_cnt", bus.Cyc_cnt, 32'd0);
    chk("t5_stl_cnt", bus.Stl_cnt, 32'd0);
    chk("t5_ret_cnt", bus.Ret_cnt, 32'd0);
`endif
    chk("t5_err", {31'b0, bus.Stall_err}, 32'h0);

    // 6: nop stream is valid but never retires.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(32'h0, 32'h600 + 32'(4 * i), 1'b0);
      if (i >= 2) begin
        chk("t6_valid_w", {31'b0, bus.Valid_W}, 32'h1);
        chk("t6_retire_w", {31'b0, bus.Retire_W}, 32'h0);
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
